// File: rtl/key_unwrap_pkg.sv
// Shared types and defaults for the key unwrap session controller.
// Holds the FSM state encoding and the counter width helper.
package key_unwrap_pkg;

  typedef enum logic [2:0] {
    LOAD_KEY,
    PASS_ENTRY,
    PASS_CHECK,
    LOCKOUT,
    LOAD_BLOCK,
    CRYPT,
    EMIT
  } state_e;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_KEY_WORDS = 268;
  localparam int DEF_BLK_WORDS = 8;
  localparam int DEF_PASS_MAX  = 56;
  localparam int DEF_MAX_TRIES = 3;
  localparam int DEF_LOCK_CYC  = 1024;

  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/key_unwrap_ctrl_deser.sv
// Word-serial valid/ready deserialiser into a flat buffer.
// full pulses combinationally with the last word's transfer.
module word_deser #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       data,
  input  logic                    valid,
  output logic                    ready,
  output logic                    full,
  output logic [WORDS*DATA_W-1:0] words
);
  import key_unwrap_pkg::*;

  localparam int IW = cnt_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] mem_q [WORDS];
  logic              take;

  assign ready = en;
  assign take  = en && valid;
  assign full  = take && (idx_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clr || full) begin
      idx_q <= '0;
    end else if (take) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (take) begin
      for (int i = 0; i < WORDS; i++)
        if (idx_q == IW'(i)) mem_q[i] <= data;
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_pack
    assign words[g*DATA_W +: DATA_W] = mem_q[g];
  end

endmodule

// File: rtl/key_unwrap_ctrl.sv
// Session controller: key blob load, passphrase check with lockout,
// then per-block deserialise, modexp round trip and serialised output.
module key_unwrap_ctrl #(
  parameter int DATA_W    = 32,
  parameter int KEY_WORDS = 268,
  parameter int BLK_WORDS = 8,
  parameter int PASS_MAX  = 56,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYC  = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           key_data_i,
  input  logic                        key_valid_i,
  output logic                        key_ready_o,
  output logic [KEY_WORDS*DATA_W-1:0] key_blob_o,
  input  logic [7:0]                  kbd_data_i,
  input  logic                        kbd_valid_i,
  input  logic                        kbd_enter_i,
  input  logic                        kbd_clear_i,
  output logic [8*PASS_MAX-1:0]       pass_buf_o,
  output logic [$clog2(PASS_MAX+1)-1:0] pass_len_o,
  output logic                        chk_req_o,
  input  logic                        chk_ack_i,
  input  logic                        chk_ok_i,
  input  logic [DATA_W-1:0]           blk_data_i,
  input  logic                        blk_valid_i,
  output logic                        blk_ready_o,
  output logic [BLK_WORDS*DATA_W-1:0] eng_block_o,
  output logic                        eng_start_o,
  input  logic                        eng_done_i,
  input  logic                        eng_err_i,
  input  logic [BLK_WORDS*DATA_W-1:0] eng_result_i,
  output logic [DATA_W-1:0]           out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        out_last_o,
  output logic                        led_pass_o,
  output logic                        led_fail_o,
  output logic                        locked_o
);
  import key_unwrap_pkg::*;

  localparam int PW = $clog2(PASS_MAX + 1);
  localparam int TW = cnt_w(MAX_TRIES);
  localparam int LW = cnt_w(LOCK_CYC);
  localparam int OW = cnt_w(BLK_WORDS);
  localparam logic [PW-1:0] PASS_FULL = PW'(PASS_MAX);
  localparam logic [TW-1:0] TRY_LAST  = TW'(MAX_TRIES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);
  localparam logic [OW-1:0] OUT_LAST  = OW'(BLK_WORDS - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     tries_q;
  logic [LW-1:0]     lock_q;
  logic [OW-1:0]     oidx_q;
  logic [PW-1:0]     len_q;
  logic [8*PASS_MAX-1:0] pass_q;
  logic [DATA_W-1:0] res_q [BLK_WORDS];
  logic              led_pass_q, led_fail_q, started_q;

  logic key_full, blk_full;
  logic kbd_act, do_clear, do_enter, do_byte;
  logic chk_done, eng_fin, eng_ok, eng_bad;
  logic out_fire, out_end, lock_end;

  word_deser #(.DATA_W(DATA_W), .WORDS(KEY_WORDS)) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == LOAD_KEY),
    .clr   (state_q != LOAD_KEY),
    .data  (key_data_i),
    .valid (key_valid_i),
    .ready (key_ready_o),
    .full  (key_full),
    .words (key_blob_o)
  );

  word_deser #(.DATA_W(DATA_W), .WORDS(BLK_WORDS)) u_blk (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == LOAD_BLOCK),
    .clr   (state_q != LOAD_BLOCK),
    .data  (blk_data_i),
    .valid (blk_valid_i),
    .ready (blk_ready_o),
    .full  (blk_full),
    .words (eng_block_o)
  );

  assign kbd_act  = (state_q == PASS_ENTRY) && kbd_valid_i;
  assign do_clear = kbd_act && kbd_clear_i;
  assign do_enter = kbd_act && !kbd_clear_i && kbd_enter_i && (len_q != '0);
  assign do_byte  = kbd_act && !kbd_clear_i && !kbd_enter_i && (len_q != PASS_FULL);
  assign chk_done = (state_q == PASS_CHECK) && chk_ack_i;
  assign lock_end = (state_q == LOCKOUT) && (lock_q == LOCK_LAST);
  // a done coinciding with the start pulse belongs to no request of ours
  assign eng_fin  = (state_q == CRYPT) && started_q && eng_done_i;
  assign eng_ok   = eng_fin && !eng_err_i;
  assign eng_bad  = eng_fin && eng_err_i;
  assign out_fire = (state_q == EMIT) && out_ready_i;
  assign out_end  = out_fire && (oidx_q == OUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD_KEY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD_KEY:   if (key_full) state_d = PASS_ENTRY;
      PASS_ENTRY: if (do_enter) state_d = PASS_CHECK;
      PASS_CHECK: begin
        if (chk_done) begin
          if (chk_ok_i)              state_d = LOAD_BLOCK;
          else if (tries_q == TRY_LAST) state_d = LOCKOUT;
          else                       state_d = PASS_ENTRY;
        end
      end
      LOCKOUT:    if (lock_end) state_d = PASS_ENTRY;
      LOAD_BLOCK: if (blk_full) state_d = CRYPT;
      CRYPT: begin
        if (eng_ok)       state_d = EMIT;
        else if (eng_bad) state_d = LOAD_BLOCK;
      end
      EMIT:       if (out_end) state_d = LOAD_BLOCK;
      default:    state_d = LOAD_KEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      pass_q <= '0;
    end else if (do_clear || chk_done) begin
      len_q  <= '0;
      pass_q <= '0;
    end else if (do_byte) begin
      len_q <= len_q + 1'b1;
      for (int i = 0; i < PASS_MAX; i++)
        if (len_q == PW'(i)) pass_q[8*i +: 8] <= kbd_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tries_q    <= '0;
      lock_q     <= '0;
      led_pass_q <= 1'b0;
      led_fail_q <= 1'b0;
    end else begin
      if (chk_done && chk_ok_i) begin
        led_pass_q <= 1'b1;
        tries_q    <= '0;
      end else if (chk_done) begin
        led_fail_q <= 1'b1;
        tries_q    <= tries_q + 1'b1;
      end else if (lock_end) begin
        tries_q <= '0;
      end
      if (do_byte && len_q == '0) led_fail_q <= 1'b0;
      if (eng_bad)                led_fail_q <= 1'b1;
      if (state_q != LOCKOUT || lock_end) lock_q <= '0;
      else                                lock_q <= lock_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      oidx_q    <= '0;
      for (int i = 0; i < BLK_WORDS; i++) res_q[i] <= '0;
    end else begin
      started_q <= (state_q == CRYPT) && !eng_fin;
      if (eng_ok)
        for (int i = 0; i < BLK_WORDS; i++)
          res_q[i] <= eng_result_i[i*DATA_W +: DATA_W];
      if (out_end)       oidx_q <= '0;
      else if (out_fire) oidx_q <= oidx_q + 1'b1;
    end
  end

  always_comb begin
    out_data_o = '0;
    for (int i = 0; i < BLK_WORDS; i++)
      if (state_q == EMIT && oidx_q == OW'(i)) out_data_o = res_q[i];
  end

  assign pass_buf_o  = pass_q;
  assign pass_len_o  = len_q;
  assign chk_req_o   = (state_q == PASS_CHECK);
  assign locked_o    = (state_q == LOCKOUT);
  assign eng_start_o = (state_q == CRYPT) && !started_q;
  assign out_valid_o = (state_q == EMIT);
  assign out_last_o  = (state_q == EMIT) && (oidx_q == OUT_LAST);
  assign led_pass_o  = led_pass_q;
  assign led_fail_o  = led_fail_q;

endmodule

// File: tb/tb_key_unwrap_ctrl.sv
// Directed bench for key_unwrap_ctrl; output stream checked by a
// queue-based scoreboard monitor running on the falling edge.
module tb_key_unwrap_ctrl;

  localparam int DW = 32;
  localparam int KW = 268;
  localparam int BW = 8;
  localparam int PM = 56;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] key_data_i = '0;
  logic key_valid_i = 1'b0;
  logic key_ready_o;
  logic [KW*DW-1:0] key_blob_o;
  logic [7:0] kbd_data_i = '0;
  logic kbd_valid_i = 1'b0, kbd_enter_i = 1'b0, kbd_clear_i = 1'b0;
  logic [8*PM-1:0] pass_buf_o;
  logic [5:0] pass_len_o;
  logic chk_req_o;
  logic chk_ack_i = 1'b0, chk_ok_i = 1'b0;
  logic [DW-1:0] blk_data_i = '0;
  logic blk_valid_i = 1'b0;
  logic blk_ready_o;
  logic [BW*DW-1:0] eng_block_o;
  logic eng_start_o;
  logic eng_done_i = 1'b0, eng_err_i = 1'b0;
  logic [BW*DW-1:0] eng_result_i = '0;
  logic [DW-1:0] out_data_o;
  logic out_valid_o;
  logic out_ready_i = 1'b0;
  logic out_last_o;
  logic led_pass_o, led_fail_o, locked_o;

  key_unwrap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .key_data_i(key_data_i), .key_valid_i(key_valid_i),
    .key_ready_o(key_ready_o), .key_blob_o(key_blob_o),
    .kbd_data_i(kbd_data_i), .kbd_valid_i(kbd_valid_i),
    .kbd_enter_i(kbd_enter_i), .kbd_clear_i(kbd_clear_i),
    .pass_buf_o(pass_buf_o), .pass_len_o(pass_len_o),
    .chk_req_o(chk_req_o), .chk_ack_i(chk_ack_i), .chk_ok_i(chk_ok_i),
    .blk_data_i(blk_data_i), .blk_valid_i(blk_valid_i),
    .blk_ready_o(blk_ready_o), .eng_block_o(eng_block_o),
    .eng_start_o(eng_start_o), .eng_done_i(eng_done_i),
    .eng_err_i(eng_err_i), .eng_result_i(eng_result_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_last_o(out_last_o),
    .led_pass_o(led_pass_o), .led_fail_o(led_fail_o),
    .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic tog_en = 1'b0;
  logic hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic [DW:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kbd(input logic [7:0] b, input logic ent, input logic clr);
    kbd_data_i  = b;
    kbd_enter_i = ent;
    kbd_clear_i = clr;
    kbd_valid_i = 1'b1;
    tick();
    kbd_valid_i = 1'b0;
    kbd_enter_i = 1'b0;
    kbd_clear_i = 1'b0;
  endtask

  task automatic ack(input logic ok);
    chk_ack_i = 1'b1;
    chk_ok_i  = ok;
    tick();
    chk_ack_i = 1'b0;
    chk_ok_i  = 1'b0;
  endtask

  task automatic send_blk(input logic [DW-1:0] base);
    for (int i = 0; i < BW; i++) begin
      blk_data_i  = base + DW'(i);
      blk_valid_i = 1'b1;
      tick();
    end
    blk_valid_i = 1'b0;
  endtask

  task automatic set_result(input logic [DW-1:0] base);
    for (int i = 0; i < BW; i++)
      eng_result_i[i*DW +: DW] = base + DW'(i);
  endtask

  // scoreboard monitor: transfers and stall stability seen on negedge
  always @(negedge clk) begin
    if (eng_start_o) starts++;
    if (out_valid_o) begin
      if (hold_v) check("out_stable", out_data_o, hold_d);
      if (out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", {out_last_o, out_data_o}, '1);
        end else begin
          check("out_word", {out_last_o, out_data_o}, exp_q.pop_front());
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_d = out_data_o;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) out_ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    int lk;
    #3;
    check("rst_key_ready", key_ready_o, 1);
    check("rst_status", {chk_req_o, blk_ready_o, eng_start_o, out_valid_o,
                         out_last_o, led_pass_o, led_fail_o, locked_o}, 0);
    check("rst_bufs", |{key_blob_o, pass_buf_o, eng_block_o, out_data_o,
                        pass_len_o}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < KW; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      key_data_i  = DW'(i);
      key_valid_i = 1'b1;
      tick();
      key_valid_i = 1'b0;
    end
    check("key_ready_drop", key_ready_o, 0);
    n = 0;
    for (int i = 0; i < KW; i++)
      if (key_blob_o[i*DW +: DW] !== DW'(i)) n++;
    check("key_blob_words_bad", n, 0);
    check("key_blob_w267", key_blob_o[267*DW +: DW], 267);

    kbd(8'h00, 1'b1, 1'b0);
    check("enter_empty_req", chk_req_o, 0);
    for (int i = 0; i < 60; i++) kbd(8'(i + 1), 1'b0, 1'b0);
    check("len_cap", pass_len_o, 56);
    check("byte55", pass_buf_o[8*55 +: 8], 56);
    check("byte0", pass_buf_o[7:0], 1);
    kbd(8'h00, 1'b0, 1'b1);
    check("clear_len", pass_len_o, 0);

    for (int t = 0; t < 3; t++) begin
      kbd(8'h70, 1'b0, 1'b0);
      if (t > 0) check("fail_led_clear", led_fail_o, 0);
      kbd(8'h00, 1'b1, 1'b0);
      check("req_try", chk_req_o, 1);
      ack(1'b0);
      check("fail_led", led_fail_o, 1);
      check("locked_try", locked_o, (t == 2) ? 1 : 0);
      check("req_drop", chk_req_o, 0);
    end
    check("fail_buf_zero", pass_len_o, 0);
    lk = 0;
    n  = 0;
    while (locked_o && n < 2000) begin
      kbd_data_i  = 8'h55;
      kbd_enter_i = 1'(lk % 2);
      kbd_valid_i = 1'b1;
      tick();
      lk++;
      n++;
    end
    kbd_valid_i = 1'b0;
    kbd_enter_i = 1'b0;
    check("lock_cycles", lk, 1024);
    check("lock_typing", pass_len_o, 0);
    check("post_lock_req", chk_req_o, 0);

    kbd("a", 1'b0, 1'b0);
    kbd("b", 1'b0, 1'b0);
    kbd("c", 1'b0, 1'b0);
    kbd(8'h00, 1'b0, 1'b1);
    kbd("x", 1'b0, 1'b0);
    kbd("y", 1'b0, 1'b0);
    kbd(8'h00, 1'b1, 1'b0);
    check("req_ok", chk_req_o, 1);
    check("req_len", pass_len_o, 2);
    check("req_buf", pass_buf_o[23:0], 24'h00_79_78);
    check("led_fail_cleared", led_fail_o, 0);
    ack(1'b1);
    check("led_pass", led_pass_o, 1);
    check("load_block", blk_ready_o, 1);
    check("ok_buf_zero", pass_len_o, 0);

    starts = 0;
    send_blk(32'h100);
    check("blk_ready_drop", blk_ready_o, 0);
    check("start_pulse", eng_start_o, 1);
    check("eng_blk_w0", eng_block_o[DW-1:0], 32'h100);
    check("eng_blk_w7", eng_block_o[7*DW +: DW], 32'h107);
    eng_done_i = 1'b1;
    eng_err_i  = 1'b1;
    tick();
    eng_done_i = 1'b0;
    eng_err_i  = 1'b0;
    check("done_in_start_ignored", {led_fail_o, blk_ready_o}, 0);
    repeat (19) tick();
    for (int i = 0; i < BW; i++)
      exp_q.push_back({1'(i == BW - 1), 32'hA0 + DW'(i)});
    set_result(32'hA0);
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
    tog_en = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    tog_en = 1'b0;
    out_ready_i = 1'b0;
    check("drain_timeout", exp_q.size(), 0);
    check("emit_to_load", blk_ready_o, 1);
    check("start_count", starts, 1);

    send_blk(32'h200);
    repeat (20) tick();
    eng_done_i = 1'b1;
    eng_err_i  = 1'b1;
    tick();
    eng_done_i = 1'b0;
    eng_err_i  = 1'b0;
    check("err_led", led_fail_o, 1);
    check("err_to_load", blk_ready_o, 1);
    check("err_no_out", out_valid_o, 0);

    send_blk(32'h300);
    repeat (20) tick();
    set_result(32'hB0);
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
    check("emit_valid", out_valid_o, 1);
    check("emit_w0", out_data_o, 32'hB0);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst2_key_ready", key_ready_o, 1);
    check("rst2_status", {chk_req_o, blk_ready_o, eng_start_o, out_valid_o,
                          out_last_o, led_pass_o, led_fail_o, locked_o}, 0);
    check("rst2_bufs", |{key_blob_o, pass_buf_o, eng_block_o, out_data_o,
                         pass_len_o}, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
